md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 71 +++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers and busy/done handshake
module md_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] ra, rb;
  logic        sgn;
  logic [63:0] prod;
  logic [31:0] ma, mb, uq, ur, dq, dr;
  // Signed division runs on magnitudes, then restores signs; this also covers 0x80000000 / -1.
  always_comb begin
    prod = sgn ? {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb} : {32'b0, ra} * {32'b0, rb};
    ma   = sgn && ra[31] ? -ra : ra;
    mb   = sgn && rb[31] ? -rb : rb;
    uq   = ma / (rb == 32'd0 ? 32'd1 : mb);
    ur   = ma % (rb == 32'd0 ? 32'd1 : mb);
    dq   = rb == 32'd0 ? '1 : (sgn && (ra[31] ^ rb[31]) ? -uq : uq);
    dr   = rb == 32'd0 ? ra : (sgn && ra[31] ? -ur : ur);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      ra    <= '0;
      rb    <= '0;
      sgn   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && op <= 3'd3) begin
          ra    <= a;
          rb    <= b;
          sgn   <= ~op[0];
          state <= op[1] ? DIV : MUL;
          cnt   <= op[1] ? 5'(DIV_CYCLES) : 5'(MUL_CYCLES);
          busy  <= 1'b1;
        end else if (start && op == 3'd4) begin
          hi <= a;
        end else if (start && op == 3'd5) begin
          lo <= a;
        end
      end else if (cnt == 5'd1) begin
        state    <= IDLE;
        cnt      <= '0;
        busy     <= 1'b0;
        done     <= 1'b1;
        {hi, lo} <= state == MUL ? prod : {dr, dq};
      end else begin
        cnt <= cnt - 5'd1;
      end
    end
  end
endmodule
